// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the ID/EX pipeline stage
package pipeline_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;
  localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic [1:0] resultsrc;
  } ex_ctrl_t;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the freshest value of one EX source register from MEM, WB or the register file
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      regwrite_m,
  input  logic [DATA_WIDTH-1:0]     alu_result_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      regwrite_w,
  input  logic [DATA_WIDTH-1:0]     result_w,
  output fwd_sel_t                  sel,
  output logic [DATA_WIDTH-1:0]     data
);
  // MEM is younger than WB so it wins; x0 is never a forwarding target
  always_comb begin
    sel  = (regwrite_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
           (regwrite_w && rd_w != '0 && rd_w == rs) ? FWD_WB : FWD_RF;
    data = (sel == FWD_MEM) ? alu_result_m : (sel == FWD_WB) ? result_w : rf_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CONTROL_WIDTH  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [CONTROL_WIDTH-1:0]  ALUctrlD,
  input  logic                      ALUsrcD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      BranchD,
  input  logic                      JumpD,
  input  logic [1:0]                ResultSrcD,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic [DATA_WIDTH-1:0]     ALUop1E,
  output logic [DATA_WIDTH-1:0]     ALUop2E,
  output logic [CONTROL_WIDTH-1:0]  ALUctrlE,
  output logic [DATA_WIDTH-1:0]     WriteDataE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      BranchE,
  output logic                      JumpE,
  output logic                      ValidE,
  output logic [1:0]                ResultSrcE,
  output logic                      LoadUseStall
);
  logic [DATA_WIDTH-1:0]     rd1_e, rd2_e, fwd1, fwd2;
  logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e;
  ex_ctrl_t                  ctrl_e;
  fwd_sel_t                  rs1_sel_unused, rs2_sel_unused;
  // E register: reset or flush loads a bubble, stall holds, otherwise capture ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rd1_e, rd2_e, ImmExtE, PCE, rs1_e, rs2_e, RdE, ALUctrlE} <= '0;
      ctrl_e <= '0;
    end else if (FlushE) begin
      {rd1_e, rd2_e, ImmExtE, PCE, rs1_e, rs2_e, RdE, ALUctrlE} <= '0;
      ctrl_e <= '0;
    end else if (!StallE) begin
      {rd1_e, rd2_e, ImmExtE, PCE} <= {RD1D, RD2D, ImmExtD, PCD};
      {rs1_e, rs2_e, RdE, ALUctrlE} <= {Rs1D, Rs2D, RdD, ALUctrlD};
      ctrl_e <= '{valid: ValidD, regwrite: RegWriteD & ValidD, memwrite: MemWriteD & ValidD,
                  branch: BranchD & ValidD, jump: JumpD & ValidD, alusrc: ALUsrcD,
                  resultsrc: ResultSrcD};
    end
  end
  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd1 (
    .rs(rs1_e), .rf_data(rd1_e), .rd_m(RdM), .regwrite_m(RegWriteM), .alu_result_m(ALUResultM),
    .rd_w(RdW), .regwrite_w(RegWriteW), .result_w(ResultW), .sel(rs1_sel_unused), .data(fwd1)
  );
  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd2 (
    .rs(rs2_e), .rf_data(rd2_e), .rd_m(RdM), .regwrite_m(RegWriteM), .alu_result_m(ALUResultM),
    .rd_w(RdW), .regwrite_w(RegWriteW), .result_w(ResultW), .sel(rs2_sel_unused), .data(fwd2)
  );
  assign ALUop1E    = fwd1;
  assign WriteDataE = fwd2;
  assign ALUop2E    = ctrl_e.alusrc ? ImmExtE : fwd2;
  assign {ValidE, RegWriteE, MemWriteE, BranchE, JumpE} =
         {ctrl_e.valid, ctrl_e.regwrite, ctrl_e.memwrite, ctrl_e.branch, ctrl_e.jump};
  assign ResultSrcE = ctrl_e.resultsrc;
  assign LoadUseStall = ctrl_e.valid && ctrl_e.resultsrc == RESULT_SRC_LOAD && RdE != '0 &&
                        ValidD && (RdE == Rs1D || RdE == Rs2D);
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register and operand-delivery stage for the 5-stage RISC-V core. Captures decoded fields from ID each cycle, resolves EX-stage data hazards by forwarding from MEM and WB, and drives the ALU operand, control and pass-through signals consumed by EX. It also flags load-use hazards to the hazard unit. It holds under stall and inserts bubbles under flush.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- REG_ADDR_WIDTH, 5, register index width
- CONTROL_WIDTH, 3, ALU control width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- StallE  in  1  hold E register contents
- FlushE  in  1  load bubble into E register
- ValidD  in  1  ID holds a real instruction
- RD1D, RD2D  in  DATA_WIDTH  register-file read data
- ImmExtD, PCD  in  DATA_WIDTH  extended immediate, instruction PC
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  source/destination indices
- ALUctrlD  in  CONTROL_WIDTH  ALU operation
- ALUsrcD  in  1  1 = op2 from immediate
- RegWriteD, MemWriteD, BranchD, JumpD  in  1 each  decoded control
- ResultSrcD  in  2  00 ALU, 01 load, 10 PC+4
- RdM, RegWriteM, ALUResultM  in  REG_ADDR_WIDTH/1/DATA_WIDTH  MEM-stage forward source
- RdW, RegWriteW, ResultW  in  REG_ADDR_WIDTH/1/DATA_WIDTH  WB-stage forward source
- ALUop1E, ALUop2E  out  DATA_WIDTH  ALU operands
- ALUctrlE  out  CONTROL_WIDTH  ALU operation
- WriteDataE  out  DATA_WIDTH  forwarded rs2 value (store data)
- PCE, ImmExtE  out  DATA_WIDTH  registered PC, immediate
- RdE  out  REG_ADDR_WIDTH  registered destination
- RegWriteE, MemWriteE, BranchE, JumpE, ValidE  out  1  registered control
- ResultSrcE  out  2  registered result select
- LoadUseStall  out  1  load-use hazard request to hazard unit

## Operation
- E register captures all D-suffixed inputs on rising clk.
- Priority per edge: FlushE > StallE > capture.
- Bubble (reset or flush): every registered field cleared to 0; ValidE, RegWriteE, MemWriteE, BranchE, JumpE = 0; ALUctrlE = 0 (add).
- Captured RegWrite/MemWrite/Branch/Jump are ANDed with ValidD.
- Forward select per source (rs1 vs Rs1E, rs2 vs Rs2E), evaluated combinationally from registered indices:
  - MEM: RegWriteM && RdM != 0 && RdM == RsxE -> ALUResultM
  - else WB: RegWriteW && RdW != 0 && RdW == RsxE -> ResultW
  - else registered RD1E/RD2E.
  - MEM beats WB when both match.
- ALUop1E = forwarded rs1; WriteDataE = forwarded rs2; ALUop2E = ALUsrcE ? ImmExtE : forwarded rs2.
- Index 0 never forwards; x0 reads return registered RD value.
- LoadUseStall = ValidE && ResultSrcE == 01 && RdE != 0 && ValidD && (RdE == Rs1D || RdE == Rs2D). Combinational, no registered state.

## Timing
- One-cycle latency from D inputs to E outputs; forwarding path is combinational, same cycle as MEM/WB values.
- Reset asserts immediately and asynchronously; all outputs read as bubble values while rst_n = 0; first capture on first rising edge after deassertion.
- StallE: outputs' registered part unchanged; forwarded operands still track live MEM/WB inputs.
- FlushE and StallE together: bubble loaded.
- Reset mid-stall: bubble, stall state discarded.
- LoadUseStall asserted in the same cycle the dependent instruction is in ID; hazard unit stalls F/D and asserts FlushE next edge.

## Structure
- pipeline_pkg: fwd_sel_t enum (FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10), RESULT_SRC_ALU/LOAD/PC4 constants, ex_ctrl_t packed struct of registered control fields.
- Sub-module forward_unit: combinational select for one operand, instantiated twice (rs1, rs2); outputs fwd_sel_t and muxed data.

## Test plan
- Reset: rst_n = 0 mid-operation -> all outputs 0, ValidE = 0, immediately; release then capture RD1D = 5, RD2D = 7, ALUctrlD = 0 -> next cycle ALUop1E = 5, ALUop2E = 7.
- MEM/WB forward: Rs1E = 3, RdM = 3, RegWriteM = 1, ALUResultM = 0x10; RdW = 3, ResultW = 0x20 -> ALUop1E = 0x10; drop RegWriteM -> 0x20; RdM = RdW = 0 -> registered RD1.
- Immediate select: ALUsrcD = 1, ImmExtD = 0xFFFFFFFC, Rs2 forwarded 0x44 -> ALUop2E = 0xFFFFFFFC, WriteDataE = 0x44.
- Stall/flush: StallE = 1 for 3 cycles with changing D inputs -> E fields unchanged; StallE = FlushE = 1 -> bubble, RegWriteE = 0.
- Load-use: ResultSrcE = 01, RdE = 4, ValidE = 1, Rs2D = 4, ValidD = 1 -> LoadUseStall = 1; RdE = 0 or ValidD = 0 -> 0.
